mc_delay_line: RTL

- Multi-lane, runtime-programmable sample delay line with built-in register storage.
- No external FIFO instance.
- CHANNELS lanes share one valid strobe and one delay setting. Each output beat is the input beat from exactly `delay` valid beats earlier.
- valid_out is withheld until the line is primed.
- Sits in streaming datapaths to align lanes or paths of unequal pipeline depth.

---
 rtl/mc_delay_line.sv | 155 +++++++++++++++
 1 files changed

// File: rtl/mc_delay_line.sv
// mc_delay_line: multi-lane, runtime-programmable sample delay line with internal register storage.
// Optional macro MC_DELAY_OUT_REG_EN registers valid_out/data_out, adding one cycle of latency.
module mc_delay_line #(
    parameter int unsigned MAX_DELAY = 128,
    parameter int unsigned WIDTH     = 32,
    parameter int unsigned CHANNELS  = 4,
    localparam int unsigned DW       = $clog2(MAX_DELAY),
    localparam int unsigned BW       = CHANNELS * WIDTH
) (
    input  logic                clk,
    input  logic                rst_n,
    input  logic                valid_in,
    input  logic [BW-1:0]       data_in,
    input  logic [CHANNELS-1:0] ch_mask,
    input  logic [DW-1:0]       delay,
    input  logic                flush,
    output logic                valid_out,
    output logic [BW-1:0]       data_out,
    output logic                primed,
    output logic [DW-1:0]       fill_level
);

    localparam logic [0:0] S_FILL = 1'b0;
    localparam logic [0:0] S_RUN  = 1'b1;

    logic [0:0]    state_q;
    logic [0:0]    state_d;
    logic [DW-1:0] wptr_q;
    logic [DW-1:0] wptr_d;
    logic [DW-1:0] wptr_inc_c;
    logic [DW-1:0] fill_q;
    logic [DW-1:0] fill_d;
    logic [DW-1:0] delay_q;
    logic [DW-1:0] rptr_c;
    logic          reprime_c;
    logic          bypass_c;
    logic          we_c;
    logic          out_valid_c;
    logic [BW-1:0] mask_c;
    logic [BW-1:0] rd_data_c;
    logic [BW-1:0] out_data_c;

    logic [BW-1:0] mem [MAX_DELAY];

    // State, pointer and delay registers
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q <= S_FILL;
            wptr_q  <= '0;
            fill_q  <= '0;
            delay_q <= '0;
        end else begin
            state_q <= state_d;
            wptr_q  <= wptr_d;
            fill_q  <= fill_d;
            delay_q <= delay;
        end
    end

    // Sample storage; contents deliberately not reset
    always_ff @(posedge clk) begin
        if (we_c) begin
            mem[wptr_q] <= data_in;
        end
    end

    // Per-lane output mask expanded to the full bus
    always_comb begin
        mask_c = '0;
        for (int k = 0; k < int'(CHANNELS); k++) begin
            mask_c[k*WIDTH +: WIDTH] = {WIDTH{ch_mask[k]}};
        end
    end

    // Read address without a power-of-two assumption; the else branch never exceeds MAX_DELAY-1
    always_comb begin
        if (wptr_q >= delay_q) begin
            rptr_c = wptr_q - delay_q;
        end else begin
            rptr_c = DW'(MAX_DELAY) - (delay_q - wptr_q);
        end
    end

    assign rd_data_c  = mem[rptr_c];
    assign wptr_inc_c = (wptr_q == DW'(MAX_DELAY - 1)) ? '0 : wptr_q + DW'(1);
    assign reprime_c  = (delay != delay_q);
    assign bypass_c   = (delay_q == '0) && !reprime_c;

    // Next-state: a re-prime restarts counting with the current beat as the first stored one
    always_comb begin
        state_d = state_q;
        fill_d  = fill_q;
        wptr_d  = wptr_q;
        we_c    = 1'b0;
        if (flush) begin
            state_d = S_FILL;
            fill_d  = '0;
            wptr_d  = '0;
        end else begin
            if (valid_in) begin
                we_c   = 1'b1;
                wptr_d = wptr_inc_c;
            end
            if (reprime_c) begin
                state_d = S_FILL;
                fill_d  = '0;
                if (valid_in && (delay != '0)) begin
                    fill_d = DW'(1);
                    if (delay == DW'(1)) begin
                        state_d = S_RUN;
                    end
                end
            end else if ((state_q == S_FILL) && valid_in && (delay_q != '0)) begin
                fill_d = fill_q + DW'(1);
                if (fill_q >= delay_q - DW'(1)) begin
                    state_d = S_RUN;
                end
            end
        end
    end

    // Output beat: bypass when delay is zero, otherwise pop the stored beat once primed
    always_comb begin
        out_valid_c = 1'b0;
        if (!flush && !reprime_c) begin
            if (bypass_c || (state_q == S_RUN)) begin
                out_valid_c = valid_in;
            end
        end
        out_data_c = '0;
        if (out_valid_c) begin
            out_data_c = (bypass_c ? data_in : rd_data_c) & mask_c;
        end
    end

    assign primed     = !reprime_c && ((delay_q == '0) || (state_q == S_RUN));
    assign fill_level = (state_q == S_RUN) ? delay_q : fill_q;

`ifdef MC_DELAY_OUT_REG_EN
    // Registered output stage
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_out <= 1'b0;
            data_out  <= '0;
        end else begin
            valid_out <= out_valid_c;
            data_out  <= out_data_c;
        end
    end
`else
    assign valid_out = out_valid_c;
    assign data_out  = out_data_c;
`endif

endmodule
